// File: rtl/sram_banked_rw.sv
// Simple-dual-port scratchpad SRAM with per-byte write masking, a registered read
// with valid strobe, a selectable read-during-write policy and a built-in clear sweep.
module sram_banked_rw #(
  parameter int n        = 16,
  parameter int depth    = 64,
  parameter int RDW_MODE = 0,
  parameter int AW       = $clog2(depth)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  output logic            busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [n-1:0]    wr_data,
  input  logic [n/8-1:0]  wr_mask,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [n-1:0]    rd_data,
  output logic            rd_valid
);

  localparam int unsigned    NB      = n / 8;
  localparam logic [AW:0]    DEPTH_W = (AW+1)'(depth);
  localparam logic [AW-1:0]  LAST    = AW'(depth - 1);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [n-1:0]    rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic [n-1:0]    mem_q [depth];

  logic            wr_fire;
  logic            rd_inrange;
  logic [n-1:0]    lane_mask;
  logic [n-1:0]    wr_merged;
  logic [n-1:0]    rd_word;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [n-1:0]    mem_wdata;

  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      lane_mask[8*i +: 8] = {8{wr_mask[i]}};
    end
  end

  // Datapath terms shared by the write merge and the write-first read bypass.
  always_comb begin
    wr_fire    = (state_q == S_READY) && !clear && wr_en &&
                 ({1'b0, wr_addr} < DEPTH_W) && (|wr_mask);
    rd_inrange = ({1'b0, rd_addr} < DEPTH_W);
    wr_merged  = (mem_q[wr_addr] & ~lane_mask) | (wr_data & lane_mask);
    rd_word    = rd_inrange ? mem_q[rd_addr] : '0;
    if ((RDW_MODE == 1) && wr_fire && (wr_addr == rd_addr)) begin
      rd_word = wr_merged;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + AW'(1);
        if (ptr_q == LAST) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (clear) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end else begin
          if (wr_fire) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_merged;
          end
          if (rd_en) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rd_word;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Array has no reset of its own; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign busy     = (state_q == S_CLEAR);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sram_banked_rw.sv
// Scoreboard bench for sram_banked_rw: three instances (read-first/64, write-first/64,
// read-first/48) share one stimulus stream; each has its own expected-read queue.
module tb_sram_banked_rw;

  logic        clk = 1'b0;
  logic        rst, clear, wr_en, rd_en;
  logic [5:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;

  logic        busy0, busy1, busy2;
  logic        rv0, rv1, rv2;
  logic [15:0] rd0, rd1, rd2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  logic [15:0] exp2[$];

  always #5 clk = ~clk;

  sram_banked_rw #(.n(16), .depth(64), .RDW_MODE(0)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd0), .rd_valid(rv0));

  sram_banked_rw #(.n(16), .depth(64), .RDW_MODE(1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd1), .rd_valid(rv1));

  sram_banked_rw #(.n(16), .depth(48), .RDW_MODE(0)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd2), .rd_valid(rv2));

  // Every rd_valid pulse pops the matching expectation.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rv0 === 1'b1) begin
      total_cnt++;
      if (exp0.size() == 0) $display("FAIL u0_unexpected_valid: got rd_data %h, required no rd_valid", rd0);
      else begin
        e = exp0.pop_front();
        if (rd0 !== e) $display("FAIL u0_rd_data: got %h required %h", rd0, e);
        else pass_cnt++;
      end
    end
    if (rv1 === 1'b1) begin
      total_cnt++;
      if (exp1.size() == 0) $display("FAIL u1_unexpected_valid: got rd_data %h, required no rd_valid", rd1);
      else begin
        e = exp1.pop_front();
        if (rd1 !== e) $display("FAIL u1_rd_data: got %h required %h", rd1, e);
        else pass_cnt++;
      end
    end
    if (rv2 === 1'b1) begin
      total_cnt++;
      if (exp2.size() == 0) $display("FAIL u2_unexpected_valid: got rd_data %h, required no rd_valid", rd2);
      else begin
        e = exp2.pop_front();
        if (rd2 !== e) $display("FAIL u2_rd_data: got %h required %h", rd2, e);
        else pass_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
  endtask

  task automatic push_all(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2);
    exp0.push_back(v0);
    exp1.push_back(v1);
    exp2.push_back(v2);
  endtask

  task automatic test_drain(input string tag);
    total_cnt++;
    if (exp0.size() != 0) $display("FAIL %s_u0_missing_reads: got %0d pending, required 0", tag, exp0.size());
    else pass_cnt++;
    total_cnt++;
    if (exp1.size() != 0) $display("FAIL %s_u1_missing_reads: got %0d pending, required 0", tag, exp1.size());
    else pass_cnt++;
    total_cnt++;
    if (exp2.size() != 0) $display("FAIL %s_u2_missing_reads: got %0d pending, required 0", tag, exp2.size());
    else pass_cnt++;
    exp0.delete();
    exp1.delete();
    exp2.delete();
  endtask

  task automatic test_reset();
    int c0, c1, c2;
    rst = 1'b1; idle(); wr_addr = '0; rd_addr = '0; wr_data = '0; wr_mask = '0;
    step(); step();
    rst = 1'b0;
    total_cnt++;
    if (busy0 !== 1'b1) $display("FAIL reset_busy: got %b required 1", busy0); else pass_cnt++;
    total_cnt++;
    if (rv0 !== 1'b0) $display("FAIL reset_rd_valid: got %b required 0", rv0); else pass_cnt++;
    total_cnt++;
    if (rd0 !== 16'h0000) $display("FAIL reset_rd_data: got %h required 0000", rd0); else pass_cnt++;
    c0 = 0; c1 = 0; c2 = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy0 === 1'b1) c0++;
      if (busy1 === 1'b1) c1++;
      if (busy2 === 1'b1) c2++;
    end
    step();
    total_cnt++;
    if (c0 != 64) $display("FAIL reset_busy_len_u0: got %0d cycles required 64", c0); else pass_cnt++;
    total_cnt++;
    if (c1 != 64) $display("FAIL reset_busy_len_u1: got %0d cycles required 64", c1); else pass_cnt++;
    total_cnt++;
    if (c2 != 48) $display("FAIL reset_busy_len_u2: got %0d cycles required 48", c2); else pass_cnt++;
    for (int a = 0; a < 64; a++) begin
      rd_en = 1'b1; rd_addr = 6'(a);
      push_all(16'h0000, 16'h0000, 16'h0000);
      step();
    end
    idle(); step(); step();
    test_drain("reset_sweep");
  endtask

  task automatic test_masked_write();
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 16'hABCD; wr_mask = 2'b11;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 6'd5;
    push_all(16'hABCD, 16'hABCD, 16'hABCD);
    step();
    total_cnt++;
    if (rv0 !== 1'b1) $display("FAIL read_latency: got rd_valid %b required 1", rv0); else pass_cnt++;
    idle();
    step();
    total_cnt++;
    if (rv0 !== 1'b0) $display("FAIL valid_one_cycle: got rd_valid %b required 0", rv0); else pass_cnt++;
    total_cnt++;
    if (rd0 !== 16'hABCD) $display("FAIL rd_data_hold: got %h required abcd", rd0); else pass_cnt++;
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 16'h1234; wr_mask = 2'b01;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 6'd5;
    push_all(16'hAB34, 16'hAB34, 16'hAB34);
    step();
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 16'h9999; wr_mask = 2'b00;
    rd_en = 1'b0;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 6'd5;
    push_all(16'hAB34, 16'hAB34, 16'hAB34);
    step();
    idle(); step(); step();
    test_drain("masked_write");
  endtask

  task automatic test_rdw();
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 16'h1111; wr_mask = 2'b11;
    step();
    wr_data = 16'h5555; rd_en = 1'b1; rd_addr = 6'd3;
    push_all(16'h1111, 16'h5555, 16'h1111);
    step();
    wr_en = 1'b0;
    push_all(16'h5555, 16'h5555, 16'h5555);
    step();
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 16'h00EE; wr_mask = 2'b01;
    push_all(16'h5555, 16'h55EE, 16'h5555);
    step();
    wr_addr = 6'd4; wr_data = 16'h7777; wr_mask = 2'b11;
    push_all(16'h55EE, 16'h55EE, 16'h55EE);
    step();
    idle(); step(); step();
    test_drain("rdw");
  endtask

  task automatic test_clear_sweep();
    int vcount;
    int guard;
    for (int a = 0; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = 6'(a); wr_data = 16'(16'h1000 + a * 16'h0101); wr_mask = 2'b11;
      step();
    end
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 6'd7;
    push_all(16'h1707, 16'h1707, 16'h1707);
    step();
    rd_en = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    total_cnt++;
    if (busy0 !== 1'b1) $display("FAIL clear_busy_rise: got %b required 1", busy0); else pass_cnt++;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i % 8); wr_data = 16'hBEEF; wr_mask = 2'b11;
      rd_en = 1'b1; rd_addr = 6'(i % 8);
      step();
      if (rv0 === 1'b1 || rv1 === 1'b1 || rv2 === 1'b1) vcount++;
    end
    idle();
    total_cnt++;
    if (vcount != 0) $display("FAIL clear_no_valid: got %0d pulses required 0", vcount); else pass_cnt++;
    guard = 0;
    while (busy0 === 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    total_cnt++;
    if (busy0 !== 1'b0) $display("FAIL clear_busy_fall: got busy %b after %0d cycles required 0", busy0, guard);
    else pass_cnt++;
    for (int a = 0; a < 8; a++) begin
      rd_en = 1'b1; rd_addr = 6'(a);
      push_all(16'h0000, 16'h0000, 16'h0000);
      step();
    end
    idle(); step(); step();
    test_drain("clear_sweep");
  endtask

  task automatic test_reset_mid_clear();
    int c0, c1, c2;
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    c0 = 0; c1 = 0; c2 = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy0 === 1'b1) c0++;
      if (busy1 === 1'b1) c1++;
      if (busy2 === 1'b1) c2++;
      clear = (c < 45) && (c % 7 == 3);
    end
    step();
    clear = 1'b0;
    total_cnt++;
    if (c0 != 64) $display("FAIL restart_busy_len_u0: got %0d cycles required 64", c0); else pass_cnt++;
    total_cnt++;
    if (c1 != 64) $display("FAIL restart_busy_len_u1: got %0d cycles required 64", c1); else pass_cnt++;
    total_cnt++;
    if (c2 != 48) $display("FAIL restart_busy_len_u2: got %0d cycles required 48", c2); else pass_cnt++;
    test_drain("reset_mid_clear");
  endtask

  task automatic test_out_of_range();
    wr_en = 1'b1; wr_addr = 6'd47; wr_data = 16'h4747; wr_mask = 2'b11;
    step();
    wr_addr = 6'd50; wr_data = 16'hFFFF;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 6'd50;
    push_all(16'hFFFF, 16'hFFFF, 16'h0000);
    step();
    rd_addr = 6'd47;
    push_all(16'h4747, 16'h4747, 16'h4747);
    step();
    idle(); step(); step();
    test_drain("out_of_range");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_masked_write();
    test_rdw();
    test_clear_sweep();
    test_reset_mid_clear();
    test_out_of_range();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
